// File: rtl/pingpong_buf.sv
// Two-entry ping-pong buffer feeding a 2:1 mux. Words land alternately in
// bank 0 and bank 1. The read pointer s drives the mux select, so the mux
// output is always the oldest unread word.
// Optional build macro: PINGPONG_ERR_FLAG_EN enables the sticky protocol
// error flag. Without it, err is tied to 0.
module pingpong_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic             s,
  output logic [1:0]       count,
  output logic             err
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHalf  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             wr_ptr_q;
  logic             s_q;
  logic [WIDTH-1:0] bank0_q, bank1_q;
  logic             wr_acc, rd_acc;

  // Handshake decode from registered state only, plus next-state logic.
  always_comb begin
    wr_ready = (state_q != StFull);
    rd_valid = (state_q != StEmpty);
    wr_acc   = wr_en & wr_ready;
    rd_acc   = rd_en & rd_valid;
    state_d  = state_q;
    unique case (state_q)
      StEmpty: if (wr_acc) state_d = StHalf;
      StHalf: begin
        // A simultaneous write and read leaves occupancy unchanged.
        if (wr_acc && !rd_acc)      state_d = StFull;
        else if (rd_acc && !wr_acc) state_d = StEmpty;
      end
      StFull:  if (rd_acc) state_d = StHalf;
      default: state_d = StEmpty;
    endcase
  end

  // State, bank and pointer registers. Reset wins over any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      wr_ptr_q <= 1'b0;
      s_q      <= 1'b0;
      bank0_q  <= '0;
      bank1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (wr_acc) begin
        if (wr_ptr_q) bank1_q <= wr_data;
        else          bank0_q <= wr_data;
        wr_ptr_q <= ~wr_ptr_q;
      end
      // Reads only advance the pointer; bank contents stay visible.
      if (rd_acc) s_q <= ~s_q;
    end
  end

  assign d0    = bank0_q;
  assign d1    = bank1_q;
  assign s     = s_q;
  assign count = state_q;

`ifdef PINGPONG_ERR_FLAG_EN
  logic err_q;

  // Sticky flag: any request the buffer cannot honour sets it until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((wr_en && !wr_ready) || (rd_en && !rd_valid)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/pingpong_buf.md
Name: pingpong_buf

Overview:
Two-entry ping-pong buffer that sits directly upstream of the 2:1 mux (mux2). It captures a stream of WIDTH-bit words alternately into bank 0 and bank 1. It presents both banks as d0/d1 and drives the mux select s, so the mux output y is always the oldest unread word. A valid/ready-style handshake runs on both the write side and the read side.

Parameters:
WIDTH, 4, data width of each bank; matches mux2 d0/d1/y width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
wr_en  input  1  producer requests write of wr_data this cycle
wr_data  input  WIDTH  word to store
wr_ready  output  1  buffer can accept a write (state != FULL)
rd_en  input  1  consumer pops the word currently shown on mux y
rd_valid  output  1  mux y holds an unread word (state != EMPTY)
d0  output  WIDTH  bank 0 contents; connects to mux2 d0
d1  output  WIDTH  bank 1 contents; connects to mux2 d1
s  output  1  read pointer; connects to mux2 s (0 selects d0, 1 selects d1)
count  output  2  number of unread words, 0..2
err  output  1  sticky protocol error (see Optional Feature)

Behaviour:
- Clocking and reset: single clock domain; every register updates on posedge clk.
- Reset values: reset high at a posedge sets d0=0, d1=0, s=0, wr_ptr=0, state=EMPTY, count=0, wr_ready=1, rd_valid=0, err=0.
- Reset mid-operation: reset overrides any wr_en/rd_en in the same cycle; stored data is discarded.
- State machine: EMPTY (count 0), HALF (count 1), FULL (count 2).
- wr_ready and rd_valid are decoded combinationally from the registered state only. They never depend on wr_en or rd_en.
- Write acceptance: wr_acc = wr_en & wr_ready. On wr_acc, bank[wr_ptr] <= wr_data and wr_ptr toggles. The other bank is unchanged.
- Read acceptance: rd_acc = rd_en & rd_valid. On rd_acc, s toggles. Bank contents are not cleared on read.
- Write and read pointers wrap modulo 2 (single-bit toggle).
- Transitions:
  - EMPTY: wr_acc -> HALF; rd_en is ignored.
  - HALF: wr_acc only -> FULL; rd_acc only -> EMPTY; both in the same cycle -> stay HALF, write lands in bank[wr_ptr] while s advances.
  - FULL: rd_acc -> HALF; wr_en is ignored (wr_ready=0). A simultaneous wr_en+rd_en in FULL performs the read only.
- Latency: a word written at edge N is visible on d0/d1 after edge N. rd_valid rises in the same cycle, so mux y shows the word one cycle after the write request. There is no write-to-read bypass.
- Ordering: words leave strictly in write order; s always points at the oldest unread bank.
- count equals the state encoding: EMPTY=0, HALF=1, FULL=2. count=3 is unreachable.

Optional Feature:
Macro PINGPONG_ERR_FLAG_EN.
- Defined: err is set on any cycle with (wr_en & ~wr_ready) or (rd_en & ~rd_valid). Once set, err stays 1 until reset. The offending request is still ignored as above.
- Undefined: the err port remains present but is tied to 0. No error-detection logic is synthesized. Data behaviour is identical in both builds.

Test Plan:
- Reset check: assert reset for 2 cycles with wr_en=1 and wr_data=4'hF -> d0=0, d1=0, s=0, count=0, wr_ready=1, rd_valid=0.
- Fill then drain:
  - Write 4'hA then 4'h5 -> d0=A, d1=5, count=2, wr_ready=0, y=A.
  - rd_en -> s=1, y=5, count=1.
  - rd_en -> count=0, rd_valid=0.
- Wrap-around: perform 5 write/read pairs of 1,2,3,4,5 -> y yields 1,2,3,4,5 in order; s and wr_ptr toggle each time; bank usage alternates 0,1,0,1,0.
- Simultaneous events:
  - In HALF holding 4'h3, apply wr_en(4'h9)+rd_en -> count stays 1 and y=9 next cycle.
  - In FULL, apply wr_en(4'hE)+rd_en -> read only; 4'hE is not stored and count=1.
- Boundary misuse:
  - rd_en while EMPTY -> no change to s.
  - wr_en(4'h7) while FULL -> banks unchanged.
  - With PINGPONG_ERR_FLAG_EN, err=1 from the next cycle and stays 1 until reset; without the macro, err=0 throughout.
- Reset mid-operation: in FULL holding A and 5, assert reset -> all outputs return to reset values; a subsequent write of 4'hC appears in d0 with s=0.
